vec_switch: RTL

- Central inter-core switch serving up to SWITCH_CORE_SIZE vector cores.
- It is the responder end of each core's switch send/recv interface.
- It holds one single-entry mailbox per ordered (source, destination) core pair, each entry holding one SWITCH_WIDTH-wide shortreal vector.
- A core's send deposits a vector into mailbox[self][dest]; a core's recv drains mailbox[src][self].

---
 rtl/vec_switch_pkg.sv | 16 +
 rtl/vec_switch_mailbox.sv | 41 ++++
 rtl/vec_switch.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vec_switch_pkg.sv
`default_nettype none
// ==== vec_switch_pkg : shared FSM state type and default vector/core sizes == rev 1.0 ====
package vec_switch_pkg;

  typedef enum logic [0:0] {
    SW_IDLE = 1'b0,
    SW_ACK  = 1'b1
  } VecSwitchState_t;

  localparam int c_SWITCH_WIDTH_DEF     = 16;
  localparam int c_SWITCH_CORE_SIZE_DEF = 4;
  // Vector elements travel as raw IEEE-754 single-precision bit patterns.
  localparam int c_SR_BITS              = 32;

endpackage
`default_nettype wire

// File: rtl/vec_switch_mailbox.sv
`default_nettype none
// ==== vec_switch_mailbox : single-entry mailbox, valid bit plus one vector == rev 1.0 ====
module vec_switch_mailbox
  import vec_switch_pkg::*;
#(
  parameter int SWITCH_WIDTH = c_SWITCH_WIDTH_DEF
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                write_en,
  input  logic [SWITCH_WIDTH*c_SR_BITS-1:0]   write_data,
  input  logic                                read_en,
  output logic [SWITCH_WIDTH*c_SR_BITS-1:0]   read_data,
  output logic                                full
);

  logic                              r_valid;
  logic [SWITCH_WIDTH*c_SR_BITS-1:0] r_data;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
    end else if (write_en) begin
      r_valid <= 1'b1;
    end else if (read_en) begin
      r_valid <= 1'b0;
    end
  end

  // Payload is meaningless while invalid, so it carries no reset.
  always_ff @(posedge clock) begin
    if (write_en) begin
      r_data <= write_data;
    end
  end

  assign read_data = r_data;
  assign full      = r_valid;

endmodule
`default_nettype wire

// File: rtl/vec_switch.sv
`default_nettype none
// ==== vec_switch : per-pair mailbox switch with per-core send/recv FSMs == rev 1.0 ====
module vec_switch
  import vec_switch_pkg::*;
#(
  parameter int SWITCH_WIDTH          = c_SWITCH_WIDTH_DEF,
  parameter int SWITCH_CORE_SIZE      = c_SWITCH_CORE_SIZE_DEF,
  parameter int SWITCH_CORE_ADDR_SIZE = $clog2(SWITCH_CORE_SIZE)
) (
  input  logic                                                clock,
  input  logic                                                reset,
  input  logic [SWITCH_CORE_SIZE-1:0]                         send_request,
  input  logic [SWITCH_CORE_SIZE*SWITCH_CORE_ADDR_SIZE-1:0]   send_core_idx,
  input  logic [SWITCH_CORE_SIZE*SWITCH_WIDTH*c_SR_BITS-1:0]  send_data,
  output logic [SWITCH_CORE_SIZE-1:0]                         send_ready,
  output logic [SWITCH_CORE_SIZE-1:0]                         send_ok,
  input  logic [SWITCH_CORE_SIZE-1:0]                         recv_request,
  input  logic [SWITCH_CORE_SIZE*SWITCH_CORE_ADDR_SIZE-1:0]   recv_core_idx,
  output logic [SWITCH_CORE_SIZE-1:0]                         recv_ready,
  output logic [SWITCH_CORE_SIZE*SWITCH_WIDTH*c_SR_BITS-1:0]  recv_data,
  output logic [SWITCH_CORE_SIZE*SWITCH_CORE_SIZE-1:0]        mailbox_full
);

  localparam int c_N      = SWITCH_CORE_SIZE;
  localparam int c_A      = SWITCH_CORE_ADDR_SIZE;
  localparam int c_DATA_W = SWITCH_WIDTH * c_SR_BITS;
  // One extra bit so the range check is meaningful for non power-of-2 core counts.
  localparam logic [c_A:0] c_IDX_LIM = (c_A + 1)'(SWITCH_CORE_SIZE);

  logic [c_N-1:0]      w_full_sd  [c_N];
  logic [c_DATA_W-1:0] w_rdata_sd [c_N][c_N];
  logic [c_A-1:0]      w_send_idx [c_N];
  logic [c_A-1:0]      w_recv_idx [c_N];
  logic [c_N-1:0]      w_send_acc;
  logic [c_N-1:0]      w_recv_acc;

  genvar s, d, c;

  generate
    for (s = 0; s < c_N; s++) begin : g_src
      for (d = 0; d < c_N; d++) begin : g_dst
        logic w_we;
        logic w_re;

        // Source s is the only writer and destination d the only reader.
        assign w_we = w_send_acc[s] && (w_send_idx[s] == c_A'(d));
        assign w_re = w_recv_acc[d] && (w_recv_idx[d] == c_A'(s));

        vec_switch_mailbox #(
          .SWITCH_WIDTH (SWITCH_WIDTH)
        ) u_mailbox (
          .clock      (clock),
          .reset      (reset),
          .write_en   (w_we),
          .write_data (send_data[s*c_DATA_W +: c_DATA_W]),
          .read_en    (w_re),
          .read_data  (w_rdata_sd[s][d]),
          .full       (w_full_sd[s][d])
        );

        assign mailbox_full[s*c_N + d] = w_full_sd[s][d];
      end
    end

    for (c = 0; c < c_N; c++) begin : g_core
      VecSwitchState_t     r_send_state;
      VecSwitchState_t     w_send_next;
      VecSwitchState_t     r_recv_state;
      VecSwitchState_t     w_recv_next;
      logic [c_DATA_W-1:0] r_recv_data;
      logic                w_send_idx_ok;
      logic                w_recv_idx_ok;
      logic                w_recv_src_full;

      assign w_send_idx[c]   = send_core_idx[c*c_A +: c_A];
      assign w_recv_idx[c]   = recv_core_idx[c*c_A +: c_A];
      assign w_send_idx_ok   = {1'b0, w_send_idx[c]} < c_IDX_LIM;
      assign w_recv_idx_ok   = {1'b0, w_recv_idx[c]} < c_IDX_LIM;
      assign w_recv_src_full = w_full_sd[w_recv_idx[c]][c];

      // Fullness is the pre-edge value, so a same-cycle recv never frees space for this send.
      assign send_ready[c] = (r_send_state == SW_IDLE) && w_send_idx_ok
                             && !w_full_sd[c][w_send_idx[c]];
      assign w_send_acc[c] = send_request[c] && send_ready[c];
      assign w_recv_acc[c] = recv_request[c] && (r_recv_state == SW_IDLE)
                             && w_recv_idx_ok && w_recv_src_full;

      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_send_state <= SW_IDLE;
          r_recv_state <= SW_IDLE;
          r_recv_data  <= '0;
        end else begin
          r_send_state <= w_send_next;
          r_recv_state <= w_recv_next;
          if (w_recv_acc[c]) begin
            r_recv_data <= w_rdata_sd[w_recv_idx[c]][c];
          end
        end
      end

      always_comb begin
        w_send_next = r_send_state;
        w_recv_next = r_recv_state;
        case (r_send_state)
          SW_IDLE: if (w_send_acc[c]) w_send_next = SW_ACK;
          SW_ACK:  w_send_next = SW_IDLE;
          default: w_send_next = SW_IDLE;
        endcase
        case (r_recv_state)
          SW_IDLE: if (w_recv_acc[c]) w_recv_next = SW_ACK;
          SW_ACK:  w_recv_next = SW_IDLE;
          default: w_recv_next = SW_IDLE;
        endcase
      end

      assign send_ok[c]                          = (r_send_state == SW_ACK);
      assign recv_ready[c]                       = (r_recv_state == SW_ACK);
      assign recv_data[c*c_DATA_W +: c_DATA_W]   = r_recv_data;

`ifndef SYNTHESIS
      a_send_idx_range: assert property (@(posedge clock) disable iff (!reset)
        send_request[c] |-> w_send_idx_ok);
      a_recv_idx_range: assert property (@(posedge clock) disable iff (!reset)
        recv_request[c] |-> w_recv_idx_ok);
`endif
    end
  endgenerate

endmodule
`default_nettype wire
